// File: rtl/inst_fetch_pkg.sv
// rtl/inst_fetch_pkg.sv - shared types and constants for the instruction fetch stage
package inst_fetch_pkg;

  localparam int INST_W     = 32;
  localparam int BYTE_W     = 8;
  localparam int INST_BYTES = INST_W / BYTE_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - IF stage: latches a PC, issues four byte reads, assembles a little-endian instruction
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int MAX_OUT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              pc_valid,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              br,
  input  logic              stall2,
  output logic              stall0_o,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_grant,
  input  logic              mem_rvalid,
  input  logic [BYTE_W-1:0] mem_rdata,
  output logic              inst_valid,
  output logic [ADDR_W-1:0] inst_pc,
  output logic [INST_W-1:0] inst_o
);

  localparam int               CNT_W     = $clog2(MAX_OUT + 1);
  localparam logic [CNT_W-1:0] NUM_BYTES = CNT_W'(INST_BYTES);
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(INST_BYTES - 1);

  fetch_state_e              r_state;
  logic [ADDR_W-1:0]         r_pc;
  logic [CNT_W-1:0]          r_iss_cnt;
  logic [CNT_W-1:0]          r_rcv_cnt;
  logic [CNT_W-1:0]          r_out_cnt;
  logic [CNT_W-1:0]          r_drop_cnt;
  logic [INST_W-BYTE_W-1:0]  r_asm;

  logic w_req_raw;
  logic w_grant;
  logic w_drop;
  logic w_keep;
  logic w_done;
  logic w_accept;

  // w_req_raw ignores br so a grant the arbiter sampled in a flush cycle is still counted
  always_comb begin
    w_req_raw = (r_state == ST_FETCH) && (r_iss_cnt < NUM_BYTES);
    w_grant   = mem_grant && w_req_raw;
    w_drop    = mem_rvalid && (r_drop_cnt != '0);
    w_keep    = mem_rvalid && (r_drop_cnt == '0) && (r_state == ST_FETCH);
    w_done    = w_keep && (r_rcv_cnt == LAST_BYTE);
    w_accept  = pc_valid && !br &&
                ((r_state == ST_IDLE) ||
                 ((r_state == ST_HOLD) && !stall2) ||
                 (w_done && !stall2));
  end

  assign stall0_o = !w_accept;
  assign mem_req  = w_req_raw && !br;
  assign mem_addr = r_pc + ADDR_W'(r_iss_cnt);

  // r_out_cnt tracks only live reads; doomed ones move into r_drop_cnt on br
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_pc       <= '0;
      r_iss_cnt  <= '0;
      r_rcv_cnt  <= '0;
      r_out_cnt  <= '0;
      r_drop_cnt <= '0;
      r_asm      <= '0;
      inst_valid <= 1'b0;
      inst_pc    <= '0;
      inst_o     <= '0;
    end else if (br) begin
      r_state    <= ST_IDLE;
      inst_valid <= 1'b0;
      r_iss_cnt  <= '0;
      r_rcv_cnt  <= '0;
      r_out_cnt  <= '0;
      r_drop_cnt <= r_drop_cnt + r_out_cnt + CNT_W'(w_grant) - CNT_W'(mem_rvalid);
    end else begin
      if (w_drop) begin
        r_drop_cnt <= r_drop_cnt - CNT_W'(1);
      end
      r_out_cnt <= r_out_cnt + CNT_W'(w_grant) - CNT_W'(w_keep);
      if (w_grant) begin
        r_iss_cnt <= r_iss_cnt + CNT_W'(1);
      end
      // bytes shift in from the top so byte 0 lands at bit 0 after three returns
      if (w_keep) begin
        r_rcv_cnt <= r_rcv_cnt + CNT_W'(1);
        r_asm     <= {mem_rdata, r_asm[INST_W-BYTE_W-1:BYTE_W]};
      end
      if (w_done) begin
        inst_valid <= 1'b1;
        inst_pc    <= r_pc;
        inst_o     <= {mem_rdata, r_asm};
      end else if (inst_valid && !stall2) begin
        inst_valid <= 1'b0;
      end
      if (w_accept) begin
        r_state   <= ST_FETCH;
        r_pc      <= pc_i;
        r_iss_cnt <= '0;
        r_rcv_cnt <= '0;
      end else if (w_done) begin
        r_state <= stall2 ? ST_HOLD : ST_IDLE;
      end else if ((r_state == ST_HOLD) && !stall2) begin
        r_state <= ST_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - scoreboard bench for inst_fetch with a PC source and in-order byte memory model
module tb_inst_fetch;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } ret_t;

  logic        clock;
  logic        reset;
  logic        pc_valid;
  logic [31:0] pc_i;
  logic        br;
  logic        stall2;
  logic        stall0_o;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_grant;
  logic        mem_rvalid;
  logic [7:0]  mem_rdata;
  logic        inst_valid;
  logic [31:0] inst_pc;
  logic [31:0] inst_o;
  logic        grant_force;

  int          checks;
  int          errors;
  int          cyc;
  int          lat;
  int          n_stall0_low;
  logic        last_stall0;
  logic        last_mem_req;
  logic        mon_en;
  logic        prev_v;
  logic [31:0] held_pc;
  logic [31:0] held_inst;

  exp_t        expq[$];
  ret_t        retq[$];
  logic [31:0] pcq[$];
  logic [31:0] addr_log[$];
  logic [31:0] exp_log[$];
  int          acc_cyc[$];

  inst_fetch #(.ADDR_W(32), .MAX_OUT(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .pc_valid   (pc_valid),
    .pc_i       (pc_i),
    .br         (br),
    .stall2     (stall2),
    .stall0_o   (stall0_o),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_grant  (mem_grant),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .inst_valid (inst_valid),
    .inst_pc    (inst_pc),
    .inst_o     (inst_o)
  );

  assign mem_grant = mem_req | grant_force;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    if (a == 32'h0) return 8'h13;
    if (a < 32'h4) return 8'h00;
    return a[7:0] + 8'h10 + {4'h0, a[11:8]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic chk_log(input string name);
    chk({name, "_count"}, 32'(addr_log.size()), 32'(exp_log.size()));
    for (int i = 0; i < exp_log.size() && i < addr_log.size(); i++) begin
      chk($sformatf("%s_addr%0d", name, i), addr_log[i], exp_log[i]);
    end
  endtask

  task automatic clear_logs();
    addr_log.delete();
    exp_log.delete();
    acc_cyc.delete();
    n_stall0_low = 0;
  endtask

  // Called at a falling edge; drives the PC source and memory returns, records the cycle, ends at the next falling edge
  task automatic run_cycle();
    pc_valid = (pcq.size() > 0) && !reset;
    pc_i     = (pcq.size() > 0) ? pcq[0] : 32'h0;
    if (retq.size() > 0 && retq[0].due <= cyc) begin
      mem_rvalid = 1'b1;
      mem_rdata  = mem_byte(retq[0].addr);
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = 8'h00;
    end
    #1;
    last_stall0  = stall0_o;
    last_mem_req = mem_req;
    if (mem_grant) begin
      retq.push_back('{addr: mem_addr, due: cyc + lat});
      addr_log.push_back(mem_addr);
    end
    if (mem_rvalid) void'(retq.pop_front());
    if (!stall0_o) n_stall0_low++;
    if (pc_valid && !stall0_o) begin
      void'(pcq.pop_front());
      acc_cyc.push_back(cyc);
    end
    @(posedge clock);
    cyc++;
    @(negedge clock);
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while ((expq.size() != 0 || retq.size() != 0 || pcq.size() != 0) && n < budget) begin
      run_cycle();
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s_timeout actual=%0d cycles pending_insts=%0d required=<%0d cycles", name, n, expq.size(), budget);
    end
    run_cycle();
    run_cycle();
  endtask

  // Monitor: pops the scoreboard on each new instruction and checks it stays stable while held
  initial begin
    prev_v = 1'b0;
    forever begin
      @(negedge clock);
      #2;
      if (mon_en && inst_valid === 1'b1) begin
        if (!prev_v) begin
          checks++;
          if (expq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_inst actual pc=%h inst=%h required=none", inst_pc, inst_o);
          end else begin
            exp_t e;
            e = expq.pop_front();
            if (inst_pc !== e.pc || inst_o !== e.inst) begin
              errors++;
              $display("FAIL inst actual pc=%h inst=%h required pc=%h inst=%h", inst_pc, inst_o, e.pc, e.inst);
            end
          end
          held_pc   = inst_pc;
          held_inst = inst_o;
        end else begin
          checks++;
          if (inst_pc !== held_pc || inst_o !== held_inst) begin
            errors++;
            $display("FAIL inst_hold actual pc=%h inst=%h required pc=%h inst=%h", inst_pc, inst_o, held_pc, held_inst);
          end
        end
      end
      prev_v = mon_en && (inst_valid === 1'b1);
    end
  end

  initial begin
    checks = 0; errors = 0; cyc = 0; lat = 2; n_stall0_low = 0;
    mon_en = 1'b0;
    reset = 1'b1; pc_valid = 1'b0; pc_i = 32'h0; br = 1'b0; stall2 = 1'b0;
    mem_rvalid = 1'b0; mem_rdata = 8'h00; grant_force = 1'b0;
    last_stall0 = 1'b1; last_mem_req = 1'b0;
    held_pc = 32'h0; held_inst = 32'h0;

    @(negedge clock);
    run_cycle();
    run_cycle();
    reset = 1'b0;
    chk("rst_inst_valid", 32'(inst_valid), 32'h0);
    chk("rst_inst_pc",    inst_pc,         32'h0);
    chk("rst_inst_o",     inst_o,          32'h0);
    chk("rst_mem_req",    32'(mem_req),    32'h0);
    chk("rst_stall0",     32'(stall0_o),   32'h1);
    mon_en = 1'b1;

    // 1: single fetch at 0
    clear_logs();
    pcq.push_back(32'h0);
    expq.push_back('{pc: 32'h0, inst: 32'h0000_0013});
    drain("t1", 40);
    exp_log = '{32'h0, 32'h1, 32'h2, 32'h3};
    chk_log("t1");
    chk("t1_stall0_low_cycles", 32'(n_stall0_low), 32'd1);

    // 2: back-to-back PCs, second accept in the completion cycle
    clear_logs();
    pcq.push_back(32'h0);
    pcq.push_back(32'h4);
    expq.push_back('{pc: 32'h0, inst: 32'h0000_0013});
    expq.push_back('{pc: 32'h4, inst: 32'h1716_1514});
    drain("t2", 60);
    chk("t2_accepts", 32'(acc_cyc.size()), 32'd2);
    if (acc_cyc.size() == 2) chk("t2_accept_gap", 32'(acc_cyc[1] - acc_cyc[0]), 32'd6);
    chk("t2_stall0_low_cycles", 32'(n_stall0_low), 32'd2);

    // 3: completion under stall2, held 3 cycles, release accepts next PC
    clear_logs();
    stall2 = 1'b1;
    pcq.push_back(32'h8);
    pcq.push_back(32'hC);
    expq.push_back('{pc: 32'h8, inst: 32'h1b1a_1918});
    expq.push_back('{pc: 32'hC, inst: 32'h1f1e_1d1c});
    for (int i = 0; i < 20 && inst_valid !== 1'b1; i++) run_cycle();
    chk("t3_reach_hold", 32'(inst_valid), 32'h1);
    for (int i = 0; i < 3; i++) begin
      run_cycle();
      chk("t3_stall0_in_hold", 32'(last_stall0), 32'h1);
    end
    chk("t3_pc_not_taken", 32'(pcq.size()), 32'd1);
    stall2 = 1'b0;
    run_cycle();
    chk("t3_accept_on_release", 32'(last_stall0), 32'h0);
    drain("t3", 40);

    // 4: br after two grants, no returns yet
    clear_logs();
    lat = 4;
    pcq.push_back(32'h10);
    run_cycle(); run_cycle(); run_cycle();
    br = 1'b1;
    run_cycle();
    br = 1'b0;
    chk("t4_br_stall0", 32'(last_stall0), 32'h1);
    chk("t4_br_mem_req", 32'(last_mem_req), 32'h0);
    pcq.push_back(32'h100);
    expq.push_back('{pc: 32'h100, inst: 32'h1413_1211});
    drain("t4", 40);
    exp_log = '{32'h10, 32'h11, 32'h100, 32'h101, 32'h102, 32'h103};
    chk_log("t4");

    // 5: br with a grant and an rvalid in the same cycle, plus pc_valid
    clear_logs();
    lat = 2;
    pcq.push_back(32'h20);
    pcq.push_back(32'h200);
    expq.push_back('{pc: 32'h200, inst: 32'h1514_1312});
    run_cycle(); run_cycle(); run_cycle(); run_cycle();
    br = 1'b1;
    grant_force = 1'b1;
    run_cycle();
    br = 1'b0;
    grant_force = 1'b0;
    chk("t5_br_stall0", 32'(last_stall0), 32'h1);
    chk("t5_br_mem_req", 32'(last_mem_req), 32'h0);
    run_cycle();
    chk("t5_accept_after_br", 32'(last_stall0), 32'h0);
    drain("t5", 40);
    exp_log = '{32'h20, 32'h21, 32'h22, 32'h23, 32'h200, 32'h201, 32'h202, 32'h203};
    chk_log("t5");

    // 6: address wrap, then reset mid-fetch
    clear_logs();
    pcq.push_back(32'hFFFF_FFFE);
    expq.push_back('{pc: 32'hFFFF_FFFE, inst: 32'h0013_1e1d});
    drain("t6", 40);
    exp_log = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1};
    chk_log("t6");
    pcq.push_back(32'h40);
    run_cycle(); run_cycle(); run_cycle();
    reset = 1'b1;
    run_cycle();
    retq.delete();
    reset = 1'b0;
    chk("t6_rst_inst_valid", 32'(inst_valid), 32'h0);
    chk("t6_rst_inst_pc",    inst_pc,         32'h0);
    chk("t6_rst_inst_o",     inst_o,          32'h0);
    chk("t6_rst_mem_req",    32'(mem_req),    32'h0);
    run_cycle(); run_cycle(); run_cycle();
    chk("t6_no_req_after_reset", 32'(last_mem_req), 32'h0);

    chk("end_scoreboard_empty", 32'(expq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
